// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   Decode-side stage between fetch and execute. A hold register (H) buffers
//   the fetched instruction and drives the register-file read addresses from
//   its rs/rt fields. Operands are resolved through EX/MEM/WB bypass. The
//   stage stalls while a source waits on a load. The instruction and its
//   resolved operands are then captured into an output register (O) that
//   feeds execute over a valid/ready handshake.
//
// Ports
//   clock, reset                 rising-edge clock, async active-high reset
//   if_valid/if_ready            fetch handshake
//   if_pc/if_instruction         fetched instruction
//   rf_read_address_1/2          rs / rt of the held instruction
//   rf_read_data_1/2             combinational register-file data
//   ex_fwd_*, mem_fwd_*          in-flight producers in EX and MEM
//   wb_write_*                   register-file write port (bypassed here)
//   flush                        squash H and O
//   id_valid/id_ready            execute handshake
//   id_pc/id_instruction         output instruction
//   id_operand_1/2               resolved rs / rt values
module operand_fetch_stage #(
    parameter int PC_WIDTH   = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [PC_WIDTH-1:0]   if_pc,
    input  logic [31:0]           if_instruction,
    output logic [4:0]            rf_read_address_1,
    input  logic [DATA_WIDTH-1:0] rf_read_data_1,
    output logic [4:0]            rf_read_address_2,
    input  logic [DATA_WIDTH-1:0] rf_read_data_2,
    input  logic                  ex_fwd_valid,
    input  logic [4:0]            ex_fwd_address,
    input  logic [DATA_WIDTH-1:0] ex_fwd_data,
    input  logic                  ex_fwd_is_load,
    input  logic                  mem_fwd_valid,
    input  logic [4:0]            mem_fwd_address,
    input  logic [DATA_WIDTH-1:0] mem_fwd_data,
    input  logic                  mem_fwd_pending,
    input  logic                  wb_write_enabled,
    input  logic [4:0]            wb_write_address,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    input  logic                  flush,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [PC_WIDTH-1:0]   id_pc,
    output logic [31:0]           id_instruction,
    output logic [DATA_WIDTH-1:0] id_operand_1,
    output logic [DATA_WIDTH-1:0] id_operand_2
);

    // Hold register
    logic                  h_valid_q, h_valid_d;
    logic [PC_WIDTH-1:0]   h_pc_q, h_pc_d;
    logic [31:0]           h_instr_q, h_instr_d;

    // Output register
    logic                  id_valid_q, id_valid_d;
    logic [PC_WIDTH-1:0]   id_pc_q, id_pc_d;
    logic [31:0]           id_instr_q, id_instr_d;
    logic [DATA_WIDTH-1:0] id_op1_q, id_op1_d;
    logic [DATA_WIDTH-1:0] id_op2_q, id_op2_d;

    // Index 0 = rs, index 1 = rt
    logic [1:0][4:0]            src;
    logic [1:0][DATA_WIDTH-1:0] rf_data;
    logic [1:0][DATA_WIDTH-1:0] opnd;
    logic [1:0]                 src_hz;

    logic hazard;
    logic h_fire;
    logic accept;

    assign src[0]     = h_instr_q[25:21];
    assign src[1]     = h_instr_q[20:16];
    assign rf_data[0] = rf_read_data_1;
    assign rf_data[1] = rf_read_data_2;

    assign rf_read_address_1 = src[0];
    assign rf_read_address_2 = src[1];

    // Both fields are checked whatever the opcode: a spurious stall is
    // harmless, a missed one is not. $0 never waits on a producer.
    // The resolution chain is evaluated every cycle, so a stalled
    // instruction picks up its producer as it moves from EX to MEM to WB.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            src_hz[i] = (src[i] != 5'd0) &&
                        ((ex_fwd_valid && ex_fwd_is_load && ex_fwd_address == src[i]) ||
                         (mem_fwd_valid && mem_fwd_pending && mem_fwd_address == src[i]));
            if (src[i] == 5'd0)
                opnd[i] = '0;
            else if (ex_fwd_valid && !ex_fwd_is_load && ex_fwd_address == src[i])
                opnd[i] = ex_fwd_data;
            else if (mem_fwd_valid && !mem_fwd_pending && mem_fwd_address == src[i])
                opnd[i] = mem_fwd_data;
            // The register file writes at the edge but reads combinationally,
            // so the value being written this cycle must be bypassed.
            else if (wb_write_enabled && wb_write_address == src[i])
                opnd[i] = wb_write_data;
            else
                opnd[i] = rf_data[i];
        end
    end

    assign hazard   = |src_hz;
    assign h_fire   = h_valid_q && !hazard && (!id_valid_q || id_ready);
    assign if_ready = !flush && (!h_valid_q || h_fire);
    assign accept   = if_valid && if_ready;

    always_comb begin
        h_valid_d  = h_valid_q;
        h_pc_d     = h_pc_q;
        h_instr_d  = h_instr_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_op1_d   = id_op1_q;
        id_op2_d   = id_op2_q;
        if (flush) begin
            h_valid_d  = 1'b0;
            id_valid_d = 1'b0;
        end else begin
            if (accept) begin
                h_valid_d = 1'b1;
                h_pc_d    = if_pc;
                h_instr_d = if_instruction;
            end else if (h_fire) begin
                h_valid_d = 1'b0;
            end
            if (h_fire) begin
                id_valid_d = 1'b1;
                id_pc_d    = h_pc_q;
                id_instr_d = h_instr_q;
                id_op1_d   = opnd[0];
                id_op2_d   = opnd[1];
            end else if (id_valid_q && id_ready) begin
                id_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_valid_q  <= 1'b0;
            h_pc_q     <= '0;
            h_instr_q  <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= '0;
            id_op1_q   <= '0;
            id_op2_q   <= '0;
        end else begin
            h_valid_q  <= h_valid_d;
            h_pc_q     <= h_pc_d;
            h_instr_q  <= h_instr_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_op1_q   <= id_op1_d;
            id_op2_q   <= id_op2_d;
        end
    end

    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_instruction = id_instr_q;
    assign id_operand_1   = id_op1_q;
    assign id_operand_2   = id_op2_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid, if_ready;
    logic [31:0] if_pc, if_instruction;
    logic [4:0]  rf_read_address_1, rf_read_address_2;
    logic [31:0] rf_read_data_1, rf_read_data_2;
    logic        ex_fwd_valid, ex_fwd_is_load;
    logic [4:0]  ex_fwd_address;
    logic [31:0] ex_fwd_data;
    logic        mem_fwd_valid, mem_fwd_pending;
    logic [4:0]  mem_fwd_address;
    logic [31:0] mem_fwd_data;
    logic        wb_write_enabled;
    logic [4:0]  wb_write_address;
    logic [31:0] wb_write_data;
    logic        flush;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_instruction, id_operand_1, id_operand_2;

    logic [31:0] rf_mem [0:31];
    assign rf_read_data_1 = rf_mem[rf_read_address_1];
    assign rf_read_data_2 = rf_mem[rf_read_address_2];

    always #5 clock = ~clock;

    operand_fetch_stage #(.PC_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instruction(if_instruction),
        .rf_read_address_1(rf_read_address_1), .rf_read_data_1(rf_read_data_1),
        .rf_read_address_2(rf_read_address_2), .rf_read_data_2(rf_read_data_2),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_address(ex_fwd_address),
        .ex_fwd_data(ex_fwd_data), .ex_fwd_is_load(ex_fwd_is_load),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_address(mem_fwd_address),
        .mem_fwd_data(mem_fwd_data), .mem_fwd_pending(mem_fwd_pending),
        .wb_write_enabled(wb_write_enabled), .wb_write_address(wb_write_address),
        .wb_write_data(wb_write_data), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_instruction(id_instruction), .id_operand_1(id_operand_1), .id_operand_2(id_operand_2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, 5'd3, 5'd0, 6'h20};
    endfunction

    task automatic clr_fwd();
        ex_fwd_valid = 1'b0; ex_fwd_is_load = 1'b0; ex_fwd_address = '0; ex_fwd_data = '0;
        mem_fwd_valid = 1'b0; mem_fwd_pending = 1'b0; mem_fwd_address = '0; mem_fwd_data = '0;
        wb_write_enabled = 1'b0; wb_write_address = '0; wb_write_data = '0;
    endtask

    task automatic idle();
        if_valid = 1'b0; if_pc = '0; if_instruction = '0;
        flush = 1'b0; id_ready = 1'b1;
        clr_fwd();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_if_ready", if_ready, 1);
        chk("rst_addr1", rf_read_address_1, 0);
        chk("rst_addr2", rf_read_address_2, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_op1", id_operand_1, 0);
        reset = 1'b0;
    endtask

    // Directed resolution vectors
    typedef struct {
        logic [4:0]  rs, rt;
        logic        ex_v, ex_ld; logic [4:0] ex_a;  logic [31:0] ex_d;
        logic        mem_v, mem_p; logic [4:0] mem_a; logic [31:0] mem_d;
        logic        wb_e; logic [4:0] wb_a; logic [31:0] wb_d;
        logic        stall;
        logic [31:0] op1, op2;
    } vec_t;
    vec_t tv [12];

    // Reference model: the stage as two one-deep queues
    typedef struct {
        logic [31:0] pc, ins, o1, o2;
    } ent_t;
    ent_t hq[$];
    ent_t oq[$];

    function automatic logic waits(input logic [4:0] s);
        if (s == 0) return 1'b0;
        if (ex_fwd_valid && ex_fwd_is_load && ex_fwd_address == s) return 1'b1;
        if (mem_fwd_valid && mem_fwd_pending && mem_fwd_address == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_op(input logic [4:0] s);
        if (s == 0) return 32'h0;
        if (ex_fwd_valid && !ex_fwd_is_load && ex_fwd_address == s) return ex_fwd_data;
        if (mem_fwd_valid && !mem_fwd_pending && mem_fwd_address == s) return mem_fwd_data;
        if (wb_write_enabled && wb_write_address == s) return wb_write_data;
        return rf_mem[s];
    endfunction

    initial begin
        logic [31:0] ins;
        logic [31:0] pcn;
        logic        m_stall, m_fire, m_rdy;
        ent_t        e;

        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + i;
        rf_mem[1] = 32'd5;
        rf_mem[2] = 32'd7;

        // ---- reset and 3-instruction stream ----
        do_reset();
        if_valid = 1'b1; if_pc = 32'h100; if_instruction = mk(5'd1, 5'd2);
        @(negedge clock);
        chk("str_lat0", id_valid, 0);
        if_pc = 32'h104;
        @(negedge clock);
        chk("str_v0", id_valid, 1);
        chk("str_pc0", id_pc, 32'h100);
        chk("str_op1", id_operand_1, 5);
        chk("str_op2", id_operand_2, 7);
        if_pc = 32'h108;
        @(negedge clock);
        chk("str_pc1", id_pc, 32'h104);
        if_valid = 1'b0;
        @(negedge clock);
        chk("str_pc2", id_pc, 32'h108);
        chk("str_op1b", id_operand_1, 5);
        @(negedge clock);
        chk("str_drain", id_valid, 0);

        // ---- table-driven operand resolution ----
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + i;
        tv[0]  = '{5'd4,  5'd5,  1'b1,1'b0,5'd4, 32'h11,  1'b1,1'b0,5'd4, 32'h22,  1'b0,5'd0, 32'h0,  1'b0, 32'h11,   32'h1005};
        tv[1]  = '{5'd4,  5'd5,  1'b0,1'b0,5'd0, 32'h0,   1'b1,1'b0,5'd4, 32'h22,  1'b0,5'd0, 32'h0,  1'b0, 32'h22,   32'h1005};
        tv[2]  = '{5'd4,  5'd5,  1'b0,1'b0,5'd0, 32'h0,   1'b0,1'b0,5'd0, 32'h0,   1'b1,5'd4, 32'h33, 1'b0, 32'h33,   32'h1005};
        tv[3]  = '{5'd0,  5'd0,  1'b1,1'b1,5'd0, 32'hdead,1'b0,1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,  1'b0, 32'h0,    32'h0};
        tv[4]  = '{5'd1,  5'd8,  1'b1,1'b1,5'd8, 32'h0,   1'b0,1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,  1'b1, 32'h0,    32'h0};
        tv[5]  = '{5'd6,  5'd1,  1'b0,1'b0,5'd0, 32'h0,   1'b1,1'b1,5'd6, 32'h0,   1'b0,5'd0, 32'h0,  1'b1, 32'h0,    32'h0};
        tv[6]  = '{5'd6,  5'd1,  1'b1,1'b0,5'd6, 32'h44,  1'b1,1'b1,5'd6, 32'h0,   1'b0,5'd0, 32'h0,  1'b1, 32'h0,    32'h0};
        tv[7]  = '{5'd3,  5'd3,  1'b1,1'b0,5'd3, 32'h44,  1'b0,1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,  1'b0, 32'h44,   32'h44};
        tv[8]  = '{5'd7,  5'd1,  1'b0,1'b0,5'd0, 32'h0,   1'b0,1'b0,5'd7, 32'h77,  1'b0,5'd0, 32'h0,  1'b0, 32'h1007, 32'h1001};
        tv[9]  = '{5'd1,  5'd2,  1'b0,1'b0,5'd0, 32'h0,   1'b1,1'b0,5'd2, 32'h66,  1'b1,5'd2, 32'h55, 1'b0, 32'h1001, 32'h66};
        tv[10] = '{5'd10, 5'd11, 1'b1,1'b1,5'd9, 32'h0,   1'b0,1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,  1'b0, 32'h100a, 32'h100b};
        tv[11] = '{5'd12, 5'd13, 1'b1,1'b0,5'd13,32'h99,  1'b1,1'b0,5'd12,32'h5a,  1'b1,5'd12,32'h88, 1'b0, 32'h5a,   32'h99};
        for (int i = 0; i < 12; i++) begin
            ex_fwd_valid = tv[i].ex_v; ex_fwd_is_load = tv[i].ex_ld;
            ex_fwd_address = tv[i].ex_a; ex_fwd_data = tv[i].ex_d;
            mem_fwd_valid = tv[i].mem_v; mem_fwd_pending = tv[i].mem_p;
            mem_fwd_address = tv[i].mem_a; mem_fwd_data = tv[i].mem_d;
            wb_write_enabled = tv[i].wb_e; wb_write_address = tv[i].wb_a; wb_write_data = tv[i].wb_d;
            if_valid = 1'b1; if_pc = 32'h300 + 32'(i * 4); if_instruction = mk(tv[i].rs, tv[i].rt);
            @(negedge clock);
            if_valid = 1'b0;
            #1;
            chk($sformatf("tv%0d_if_ready", i), if_ready, !tv[i].stall);
            chk($sformatf("tv%0d_addr1", i), rf_read_address_1, tv[i].rs);
            chk($sformatf("tv%0d_addr2", i), rf_read_address_2, tv[i].rt);
            @(negedge clock);
            chk($sformatf("tv%0d_id_valid", i), id_valid, !tv[i].stall);
            if (!tv[i].stall) begin
                chk($sformatf("tv%0d_op1", i), id_operand_1, tv[i].op1);
                chk($sformatf("tv%0d_op2", i), id_operand_2, tv[i].op2);
            end
            clr_fwd();
            flush = 1'b1;
            @(negedge clock);
            flush = 1'b0;
        end

        // ---- load-use stall resolved one cycle later from MEM ----
        do_reset();
        ex_fwd_valid = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_address = 5'd8;
        if_valid = 1'b1; if_pc = 32'h200; if_instruction = mk(5'd1, 5'd8);
        @(negedge clock);
        if_pc = 32'h204; if_instruction = mk(5'd1, 5'd2);
        #1;
        chk("lu_if_ready_stall", if_ready, 0);
        @(negedge clock);
        chk("lu_no_fire", id_valid, 0);
        clr_fwd();
        mem_fwd_valid = 1'b1; mem_fwd_address = 5'd8; mem_fwd_data = 32'hAB;
        #1;
        chk("lu_if_ready_go", if_ready, 1);
        @(negedge clock);
        chk("lu_valid", id_valid, 1);
        chk("lu_pc", id_pc, 32'h200);
        chk("lu_op2", id_operand_2, 32'hAB);
        if_valid = 1'b0; clr_fwd();
        @(negedge clock);
        chk("lu_next_pc", id_pc, 32'h204);

        // ---- backpressure: 4 cycles with both registers full ----
        do_reset();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'hA00; if_instruction = mk(5'd1, 5'd2);
        @(negedge clock);
        if_pc = 32'hA04;
        @(negedge clock);
        if_pc = 32'hA08;
        #1;
        chk("bp_if_ready_full", if_ready, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk($sformatf("bp_hold%0d_valid", k), id_valid, 1);
            chk($sformatf("bp_hold%0d_pc", k), id_pc, 32'hA00);
            chk($sformatf("bp_hold%0d_op1", k), id_operand_1, 32'h1001);
            chk($sformatf("bp_hold%0d_rdy", k), if_ready, 0);
        end
        id_ready = 1'b1;
        #1;
        chk("bp_if_ready_resume", if_ready, 1);
        @(negedge clock);
        chk("bp_pc_b", id_pc, 32'hA04);
        if_valid = 1'b0;
        @(negedge clock);
        chk("bp_pc_c", id_pc, 32'hA08);
        @(negedge clock);
        chk("bp_drained", id_valid, 0);

        // ---- flush with both registers full and a fetch presented ----
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'hB00; if_instruction = mk(5'd1, 5'd2);
        @(negedge clock);
        if_pc = 32'hB04;
        @(negedge clock);
        if_pc = 32'hB08; flush = 1'b1;
        #1;
        chk("fl_if_ready_during", if_ready, 0);
        @(negedge clock);
        flush = 1'b0; if_valid = 1'b0;
        chk("fl_id_valid", id_valid, 0);
        #1;
        chk("fl_h_empty", if_ready, 1);
        id_ready = 1'b1;
        @(negedge clock);
        chk("fl_dropped", id_valid, 0);

        // ---- async reset mid-stall ----
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'hC00; if_instruction = mk(5'd1, 5'd2);
        @(negedge clock);
        if_pc = 32'hC04; if_instruction = mk(5'd1, 5'd8);
        ex_fwd_valid = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_address = 5'd8;
        @(negedge clock);
        if_valid = 1'b0;
        chk("ar_pre_valid", id_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_async_valid", id_valid, 0);
        chk("ar_async_if_ready", if_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        idle();

        // ---- randomized run against the queue model ----
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        do_reset();
        hq.delete(); oq.delete();
        pcn = 32'h4000;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            chk("rnd_id_valid", id_valid, oq.size() != 0);
            if (oq.size() != 0) begin
                chk("rnd_id_pc", id_pc, oq[0].pc);
                chk("rnd_id_ins", id_instruction, oq[0].ins);
                chk("rnd_id_op1", id_operand_1, oq[0].o1);
                chk("rnd_id_op2", id_operand_2, oq[0].o2);
            end
            ins = $urandom;
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            if_valid = ($urandom_range(0, 9) < 7);
            if_instruction = ins;
            if_pc = pcn;
            id_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 99) < 3);
            ex_fwd_valid = $urandom_range(0, 1) == 1;
            ex_fwd_is_load = ($urandom_range(0, 9) < 3);
            ex_fwd_address = 5'($urandom_range(0, 7));
            ex_fwd_data = $urandom;
            mem_fwd_valid = $urandom_range(0, 1) == 1;
            mem_fwd_pending = ($urandom_range(0, 9) < 3);
            mem_fwd_address = 5'($urandom_range(0, 7));
            mem_fwd_data = $urandom;
            wb_write_enabled = $urandom_range(0, 1) == 1;
            wb_write_address = 5'($urandom_range(0, 7));
            wb_write_data = $urandom;
            #1;
            m_stall = 1'b0;
            if (hq.size() != 0)
                m_stall = waits(hq[0].ins[25:21]) || waits(hq[0].ins[20:16]);
            m_fire = (hq.size() != 0) && !m_stall && (oq.size() == 0 || id_ready);
            m_rdy  = !flush && (hq.size() == 0 || m_fire);
            chk("rnd_if_ready", if_ready, m_rdy);
            if (hq.size() != 0) begin
                chk("rnd_addr1", rf_read_address_1, hq[0].ins[25:21]);
                chk("rnd_addr2", rf_read_address_2, hq[0].ins[20:16]);
            end
            if (flush) begin
                hq.delete(); oq.delete();
            end else begin
                if (m_fire) begin
                    e = hq.pop_front();
                    e.o1 = ref_op(e.ins[25:21]);
                    e.o2 = ref_op(e.ins[20:16]);
                    oq.delete();
                    oq.push_back(e);
                end else if (oq.size() != 0 && id_ready) begin
                    oq.delete();
                end
                if (if_valid && m_rdy) begin
                    e = '{if_pc, if_instruction, 32'h0, 32'h0};
                    hq.push_back(e);
                    pcn = pcn + 4;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
